// File: rtl/snake_game_sequencer.sv
// Snake game controller: move tick, direction latch, step req/done handshake, game FSM, BCD timer, score, beep.
// Step request issued on the tick edge and held until step_done; ticks arriving mid-step are dropped.
module snake_game_sequencer #(
  parameter int TICK_DIV  = 4500000,
  parameter int SEC_DIV   = 50000000,
  parameter int GAME_SEC  = 60,
  parameter int WIN_SCORE = 16,
  parameter int BEEP_LEN  = 5000000
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       PAUSE,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       step_done,
  input  logic       hit_item,
  input  logic       hit_body,
  output logic       step_req,
  output logic [1:0] step_dir,
  output logic [2:0] game_state,
  output logic [7:0] score,
  output logic [3:0] time_num10,
  output logic [3:0] time_num01,
  output logic       beep
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int BEEP_W = $clog2(BEEP_LEN + 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD  = BEEP_W'(BEEP_LEN - 1);
  localparam logic [3:0]        GAME_TENS  = 4'(GAME_SEC / 10);
  localparam logic [3:0]        GAME_UNITS = 4'(GAME_SEC % 10);
  localparam logic [7:0]        WIN_VAL    = 8'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSED = 3'd3,
    S_WIN    = 3'd4,
    S_LOSE   = 3'd5,
    S_TIMEUP = 3'd6
  } state_t;

  state_t              state;
  logic [1:0]          committed_dir;
  logic [1:0]          pending_dir;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SEC_W-1:0]    sec_cnt;
  logic [BEEP_W-1:0]   beep_cnt;
  logic                time_up;

  logic       one_hot;
  logic [1:0] btn_dir;
  logic       accept;
  logic       counting;
  logic       tick;
  logic       sec_wrap;
  logic [7:0] score_inc;
  logic [3:0] next_tens;
  logic [3:0] next_units;

  always_comb begin
    one_hot = 1'b0;
    btn_dir = 2'b00;
    case ({UP, DOWN, LEFT, RIGHT})
      4'b1000: begin one_hot = 1'b1; btn_dir = 2'b00; end
      4'b0100: begin one_hot = 1'b1; btn_dir = 2'b01; end
      4'b0010: begin one_hot = 1'b1; btn_dir = 2'b10; end
      4'b0001: begin one_hot = 1'b1; btn_dir = 2'b11; end
      default: ;
    endcase
    // Opposite directions share bit1 and differ in bit0
    accept    = one_hot && !((btn_dir[1] == committed_dir[1]) && (btn_dir[0] != committed_dir[0]));
    counting  = (state == S_RUN) || (state == S_STEP);
    tick      = counting && (tick_cnt == TICK_LAST);
    sec_wrap  = counting && !time_up && (sec_cnt == SEC_LAST);
    score_inc = (score == 8'hFF) ? score : score + 8'd1;
    if (time_num01 == 4'd9) begin
      next_units = 4'd0;
      next_tens  = time_num10 + 4'd1;
    end else begin
      next_units = time_num01 + 4'd1;
      next_tens  = time_num10;
    end
  end

  assign game_state = state;

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      step_req      <= 1'b0;
      step_dir      <= 2'b00;
      committed_dir <= 2'b00;
      pending_dir   <= 2'b00;
      score         <= 8'd0;
      time_num10    <= 4'd0;
      time_num01    <= 4'd0;
      beep          <= 1'b0;
      beep_cnt      <= '0;
      tick_cnt      <= '0;
      sec_cnt       <= '0;
      time_up       <= 1'b0;
    end else begin
      if (counting) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (sec_wrap) begin
        sec_cnt    <= '0;
        time_num10 <= next_tens;
        time_num01 <= next_units;
        if (next_tens == GAME_TENS && next_units == GAME_UNITS) time_up <= 1'b1;
      end else if (counting && !time_up) begin
        sec_cnt <= sec_cnt + 1'b1;
      end

      // A new hit in the step handler below overrides this countdown
      if (beep_cnt != '0) begin
        beep_cnt <= beep_cnt - 1'b1;
      end else begin
        beep <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (one_hot) begin
            state         <= S_RUN;
            pending_dir   <= btn_dir;
            committed_dir <= btn_dir;
          end
        end
        S_RUN: begin
          if (accept) pending_dir <= btn_dir;
          if (tick) begin
            state         <= S_STEP;
            step_req      <= 1'b1;
            step_dir      <= pending_dir;
            committed_dir <= pending_dir;
          end else if (time_up) begin
            state <= S_TIMEUP;
          end else if (PAUSE) begin
            state <= S_PAUSED;
          end
        end
        S_STEP: begin
          if (accept) pending_dir <= btn_dir;
          if (step_done) begin
            step_req <= 1'b0;
            if (hit_body) begin
              state <= S_LOSE;
            end else begin
              if (hit_item) begin
                score    <= score_inc;
                beep     <= 1'b1;
                beep_cnt <= BEEP_LOAD;
              end
              if (hit_item && score_inc == WIN_VAL) state <= S_WIN;
              else if (time_up)                     state <= S_TIMEUP;
              else if (PAUSE)                       state <= S_PAUSED;
              else                                  state <= S_RUN;
            end
          end
        end
        S_PAUSED: begin
          if (accept) pending_dir <= btn_dir;
          if (!PAUSE) state <= S_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule
